// File: rtl/td4x_core.sv
// td4x_core: single-cycle TD4-ISA core with a resettable program store and run/stop/step control.
// Optional HALT instruction and state are enabled by defining TD4X_HALT_EN.
module td4x_core #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [3:0]        prog_opcode,
  input  logic [DATA_W-1:0] prog_imm,
  input  logic              run,
  input  logic              step,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] out_port,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] reg_a,
  output logic [DATA_W-1:0] reg_b,
  output logic              carry,
  output logic              running,
  output logic              halted
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int WORD_W = 4 + DATA_W;

  typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_HALT} state_e;

  state_e              state_q, state_d;
  logic                running_q, halted_q;
  logic [WORD_W-1:0]   mem_q [DEPTH];
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, out_q, out_d;
  logic                c_q, c_d;
  logic [3:0]          op;
  logic [DATA_W-1:0]   imm;
  logic [ADDR_W-1:0]   jmp_tgt;
  logic                exec;
  logic                wr_en;

  assign {op, imm} = mem_q[pc_q];
  assign wr_en     = prog_we && (state_q != ST_RUN);

  // Jump target: low immediate bits, zero-filled when the immediate is narrower than the PC.
  for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_jmp
    if (gi < DATA_W) begin : g_bit
      assign jmp_tgt[gi] = imm[gi];
    end else begin : g_zero
      assign jmp_tgt[gi] = 1'b0;
    end
  end

  always_comb begin
    exec    = 1'b0;
    state_d = state_q;
    unique case (state_q)
      ST_STOP: begin
        if (run)                   state_d = ST_RUN;
        else if (step && !prog_we) exec    = 1'b1;
      end
      ST_RUN: begin
        exec = 1'b1;
        if (!run) state_d = ST_STOP;
      end
      ST_HALT: if (!run) state_d = ST_STOP;
      default: state_d = ST_STOP;
    endcase
`ifdef TD4X_HALT_EN
    // A HALT fetched on an executing edge overrides the run-level transition.
    if (exec && op == 4'b1000) state_d = ST_HALT;
`endif
  end

  always_comb begin
    pc_d  = pc_q;
    a_d   = a_q;
    b_d   = b_q;
    out_d = out_q;
    c_d   = c_q;
    if (exec) begin
      pc_d = pc_q + ADDR_W'(1);
      c_d  = 1'b0;
      case (op)
        4'b0000: {c_d, a_d} = {1'b0, a_q} + {1'b0, imm};
        4'b0101: {c_d, b_d} = {1'b0, b_q} + {1'b0, imm};
        4'b0011: a_d   = imm;
        4'b0111: b_d   = imm;
        4'b0001: a_d   = b_q;
        4'b0100: b_d   = a_q;
        4'b0010: a_d   = in_port;
        4'b0110: b_d   = in_port;
        4'b1001: out_d = b_q;
        4'b1011: out_d = imm;
        4'b1111: pc_d  = jmp_tgt;
        4'b1110: if (!c_q) pc_d = jmp_tgt;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_STOP;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == ST_RUN);
      halted_q  <= (state_d == ST_HALT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      out_q <= '0;
      c_q   <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      a_q   <= a_d;
      b_q   <= b_d;
      out_q <= out_d;
      c_q   <= c_d;
    end
  end

  // The store must clear on reset (blank program = ADD A,0), so it lives in registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[prog_addr] <= {prog_opcode, prog_imm};
    end
  end

  assign pc       = pc_q;
  assign reg_a    = a_q;
  assign reg_b    = b_q;
  assign out_port = out_q;
  assign carry    = c_q;
  assign running  = running_q;
`ifdef TD4X_HALT_EN
  assign halted   = halted_q;
`else
  assign halted   = 1'b0 & halted_q;
`endif

endmodule

// File: tb/tb_td4x_core.sv
// Testbench for td4x_core: directed vector tables, multi-cycle sequences and a random run
// against an instruction-level reference model. Honours TD4X_HALT_EN like the design.
module tb_td4x_core;
  localparam int DW   = 4;
  localparam int AW   = 4;
  localparam int DMOD = 1 << DW;
  localparam int AMOD = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [3:0]    prog_opcode = '0;
  logic [DW-1:0] prog_imm = '0;
  logic          run = 1'b0;
  logic          step = 1'b0;
  logic [DW-1:0] in_port = '0;
  logic [DW-1:0] out_port, reg_a, reg_b;
  logic [AW-1:0] pc;
  logic          carry, running, halted;

  td4x_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_opcode(prog_opcode), .prog_imm(prog_imm), .run(run), .step(step),
    .in_port(in_port), .out_port(out_port), .pc(pc), .reg_a(reg_a), .reg_b(reg_b),
    .carry(carry), .running(running), .halted(halted)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    string nm;
    bit r, s, we;
    int ad, op, im;
    int pc, a, b, out, c, rn, hl;
  } vec_t;
  vec_t vq[$];

  // reference model state: 0 = STOP, 1 = RUN, 2 = HALT
  int m_op[AMOD], m_im[AMOD];
  int m_pc, m_a, m_b, m_out, m_c, m_st;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit r, input bit s, input bit we, input int ad, input int op,
                       input int im, input int inp);
    run = r; step = s; prog_we = we;
    prog_addr = AW'(ad); prog_opcode = 4'(op); prog_imm = DW'(im); in_port = DW'(inp);
  endtask

  task automatic do_reset;
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    m_pc = 0; m_a = 0; m_b = 0; m_out = 0; m_c = 0; m_st = 0;
    for (int i = 0; i < AMOD; i++) begin m_op[i] = 0; m_im[i] = 0; end
  endtask

  task automatic load(input int ad, input int op, input int im);
    drive(0, 0, 1, ad, op, im, 0);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic model_edge(input bit r, input bit s, input bit we, input int ad, input int op,
                            input int im, input int inp);
    int nst, o, i, t;
    bit ex;
    ex = 0; nst = m_st; t = 0;
    if (m_st == 0) begin
      if (r) nst = 1; else if (s && !we) ex = 1;
    end else if (m_st == 1) begin
      ex = 1; if (!r) nst = 0;
    end else if (!r) nst = 0;
    if (ex) begin
      o = m_op[m_pc]; i = m_im[m_pc];
      case (o)
        0:  begin t = m_a + i; m_a = t % DMOD; end
        5:  begin t = m_b + i; m_b = t % DMOD; end
        3:  m_a = i;
        7:  m_b = i;
        1:  m_a = m_b;
        4:  m_b = m_a;
        2:  m_a = inp;
        6:  m_b = inp;
        9:  m_out = m_b;
        11: m_out = i;
        8:  begin
`ifdef TD4X_HALT_EN
          nst = 2;
`endif
        end
        default: ;
      endcase
      if (o == 15 || (o == 14 && m_c == 0)) m_pc = i % AMOD;
      else m_pc = (m_pc + 1) % AMOD;
      m_c = ((o == 0 || o == 5) && t >= DMOD) ? 1 : 0;
    end
    if (we && m_st != 1) begin m_op[ad] = op; m_im[ad] = im; end
    m_st = nst;
  endtask

  task automatic add_vec(input string nm, input bit r, input bit s, input bit we, input int ad,
                         input int op, input int im, input int epc, input int ea, input int eb,
                         input int eo, input int ec, input int ern, input int ehl);
    vec_t v;
    v.nm = nm; v.r = r; v.s = s; v.we = we; v.ad = ad; v.op = op; v.im = im;
    v.pc = epc; v.a = ea; v.b = eb; v.out = eo; v.c = ec; v.rn = ern; v.hl = ehl;
    vq.push_back(v);
  endtask

  task automatic apply_vecs;
    foreach (vq[k]) begin
      drive(vq[k].r, vq[k].s, vq[k].we, vq[k].ad, vq[k].op, vq[k].im, 0);
      tick;
      check({vq[k].nm, ".pc"}, int'(pc), vq[k].pc);
      check({vq[k].nm, ".a"}, int'(reg_a), vq[k].a);
      check({vq[k].nm, ".b"}, int'(reg_b), vq[k].b);
      check({vq[k].nm, ".out"}, int'(out_port), vq[k].out);
      check({vq[k].nm, ".c"}, int'(carry), vq[k].c);
      check({vq[k].nm, ".running"}, int'(running), vq[k].rn);
      check({vq[k].nm, ".halted"}, int'(halted), vq[k].hl);
    end
    vq.delete();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset;
    check("reset.pc", int'(pc), 0);
    check("reset.a", int'(reg_a), 0);
    check("reset.out", int'(out_port), 0);
    check("reset.c", int'(carry), 0);
    check("reset.running", int'(running), 0);
    check("reset.halted", int'(halted), 0);

    // Blank program free-running: ADD A,0 forever, pc wraps silently.
    run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (i == 0) check("blank.start_pc", int'(pc), 0);
      if (i == 16) check("blank.wrap_pc", int'(pc), 0);
    end
    check("blank.pc", int'(pc), 3);
    check("blank.a", int'(reg_a), 0);
    check("blank.c", int'(carry), 0);
    check("blank.running", int'(running), 1);

    // Arithmetic and carry, single-stepped.
    do_reset;
    load(0, 3, 9); load(1, 0, 9); load(2, 14, 0); load(3, 11, 5);
    add_vec("ar1", 0, 1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0);
    add_vec("ar2", 0, 1, 0, 0, 0, 0, 2, 2, 0, 0, 1, 0, 0);
    add_vec("ar3", 0, 1, 0, 0, 0, 0, 3, 2, 0, 0, 0, 0, 0);
    add_vec("ar4", 0, 1, 0, 0, 0, 0, 4, 2, 0, 5, 0, 0, 0);
    apply_vecs;

    // Step pulses, then prog_we+step together (write wins, no execution).
    do_reset;
    load(0, 3, 3); load(1, 4, 0); load(2, 9, 0);
    add_vec("st1", 0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0);
    add_vec("st2", 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0);
    add_vec("st3", 0, 1, 0, 0, 0, 0, 2, 3, 3, 0, 0, 0, 0);
    add_vec("st4", 0, 0, 0, 0, 0, 0, 2, 3, 3, 0, 0, 0, 0);
    add_vec("st5", 0, 1, 0, 0, 0, 0, 3, 3, 3, 3, 0, 0, 0);
    add_vec("st6", 0, 1, 1, 5, 3, 6, 3, 3, 3, 3, 0, 0, 0);
    add_vec("st7", 0, 1, 0, 0, 0, 0, 4, 3, 3, 3, 0, 0, 0);
    add_vec("st8", 0, 1, 0, 0, 0, 0, 5, 3, 3, 3, 0, 0, 0);
    add_vec("st9", 0, 1, 0, 0, 0, 0, 6, 6, 3, 3, 0, 0, 0);
    apply_vecs;

    // Writes while running are ignored; the old word at addr 2 still executes.
    do_reset;
    load(2, 3, 5);
    add_vec("rw1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add_vec("rw2", 1, 0, 1, 2, 3, 10, 1, 0, 0, 0, 0, 1, 0);
    add_vec("rw3", 1, 0, 1, 2, 3, 10, 2, 0, 0, 0, 0, 1, 0);
    add_vec("rw4", 1, 0, 0, 0, 0, 0, 3, 5, 0, 0, 0, 1, 0);
    add_vec("rw5", 0, 0, 0, 0, 0, 0, 4, 5, 0, 0, 0, 0, 0);
    apply_vecs;

    // HALT opcode.
    do_reset;
    load(0, 3, 7); load(1, 8, 0); load(2, 3, 1);
`ifdef TD4X_HALT_EN
    add_vec("h1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add_vec("h2", 1, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1, 0);
    add_vec("h3", 1, 0, 0, 0, 0, 0, 2, 7, 0, 0, 0, 0, 1);
    add_vec("h4", 1, 0, 0, 0, 0, 0, 2, 7, 0, 0, 0, 0, 1);
    add_vec("h5", 1, 1, 0, 0, 0, 0, 2, 7, 0, 0, 0, 0, 1);
    add_vec("h6", 0, 0, 0, 0, 0, 0, 2, 7, 0, 0, 0, 0, 0);
    add_vec("h7", 1, 0, 0, 0, 0, 0, 2, 7, 0, 0, 0, 1, 0);
    add_vec("h8", 1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1, 0);
`else
    add_vec("h1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add_vec("h2", 1, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1, 0);
    add_vec("h3", 1, 0, 0, 0, 0, 0, 2, 7, 0, 0, 0, 1, 0);
    add_vec("h4", 1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1, 0);
    add_vec("h5", 1, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 1, 0);
    add_vec("h6", 0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    add_vec("h7", 1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 1, 0);
    add_vec("h8", 1, 0, 0, 0, 0, 0, 6, 1, 0, 0, 0, 1, 0);
`endif
    apply_vecs;

    // Counter loop: OUT B; ADD B,1; JNC 0; MOV A,15 -> counts 0..DMOD-1, exits on wrap.
    do_reset;
    load(0, 9, 0); load(1, 5, 1); load(2, 14, 0); load(3, 3, 15);
    run = 1'b1;
    tick;
    for (int k = 0; k < DMOD; k++) begin
      tick;
      check($sformatf("cnt.out%0d", k), int'(out_port), k);
      tick;
      tick;
      check($sformatf("cnt.pc%0d", k), int'(pc), (k == DMOD - 1) ? 3 : 0);
    end
    tick;
    check("cnt.exit_pc", int'(pc), 4);
    check("cnt.exit_a", int'(reg_a), 15);
    check("cnt.exit_b", int'(reg_b), 0);
    check("cnt.exit_c", int'(carry), 0);

    // Asynchronous reset away from the clock edge clears state immediately.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst.pc", int'(pc), 0);
    check("arst.a", int'(reg_a), 0);
    check("arst.out", int'(out_port), 0);
    check("arst.running", int'(running), 0);

    // Random run against the reference model.
    do_reset;
    for (int n = 0; n < 600; n++) begin
      bit r, s, we;
      int ad, op, im, inp;
      r   = ($urandom_range(0, 9) < 6);
      s   = $urandom_range(0, 1) == 1;
      we  = ($urandom_range(0, 3) == 0);
      ad  = $urandom_range(0, AMOD - 1);
      op  = $urandom_range(0, 15);
      im  = $urandom_range(0, DMOD - 1);
      inp = $urandom_range(0, DMOD - 1);
      drive(r, s, we, ad, op, im, inp);
      tick;
      model_edge(r, s, we, ad, op, im, inp);
      check($sformatf("rnd%0d.pc", n), int'(pc), m_pc);
      check($sformatf("rnd%0d.a", n), int'(reg_a), m_a);
      check($sformatf("rnd%0d.b", n), int'(reg_b), m_b);
      check($sformatf("rnd%0d.out", n), int'(out_port), m_out);
      check($sformatf("rnd%0d.c", n), int'(carry), m_c);
      check($sformatf("rnd%0d.running", n), int'(running), (m_st == 1) ? 1 : 0);
      check($sformatf("rnd%0d.halted", n), int'(halted), (m_st == 2) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
